sl_bus_arbiter: RTL and testbench
=================================

SL_BUS_ARBITER -- requirements
Module: sl_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, the number of slave-bus requesters (range 2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port sl_arb_request  input  NUM_PORTS  per-requester "complete frame pending" flags.
REQ-005 SHALL have port sl_arb_grant  output  NUM_PORTS  one-hot-or-zero grant to the shared slave bus.
REQ-006 SHALL have port sl_addr  output  9  absolute read address into the granted requester's message FIFO.
REQ-007 SHALL have port sl_data  input  9  read data; [7:0] byte, [8] last-byte-of-frame marker, valid one cycle after sl_addr.
REQ-008 SHALL have port sl_tail  input  9  granted requester's address one past its frame's last byte.
REQ-009 SHALL have port sl_latch_tail  output  1  one-cycle pulse that releases the frame in the granted FIFO.
REQ-010 SHALL have port sl_overflow  input  1  granted requester reports a corrupted/overflowed frame.
REQ-011 SHALL have ports tx_data  output  8, tx_valid  output  1, tx_ready  input  1, tx_last  output  1: byte stream to the UART transmitter.
REQ-012 SHALL have port drop_count  output  8  number of frames discarded due to sl_overflow.

Function
REQ-013 SHALL keep a 9-bit head pointer per port, reset 0, holding the start address of that port's next frame.
REQ-014 SHALL use states IDLE, GRANT, READ, SEND, RELEASE.
REQ-015 IDLE: if any request is set, SHALL grant the first requesting port at or after rr_ptr (round-robin, wrapping at NUM_PORTS) and go to GRANT next cycle.
REQ-016 GRANT: SHALL hold grant, drive sl_addr = head[g], and sample sl_tail and sl_overflow; overflow=1 or sl_tail==head[g] -> RELEASE with no tx; else -> READ.
REQ-017 READ: SHALL wait exactly one cycle for sl_data, then go to SEND.
REQ-018 SEND: SHALL assert tx_valid with tx_data=sl_data[7:0], tx_last=1 iff sl_data[8]=1 or sl_addr+1==tail; SHALL hold data stable until tx_valid&tx_ready.
REQ-019 On a SEND handshake: if it was the last byte -> RELEASE, else sl_addr increments (mod 512) -> READ.
REQ-020 RELEASE: SHALL pulse sl_latch_tail for exactly one cycle, set head[g] = sampled tail, set rr_ptr = g+1 (mod NUM_PORTS), and deassert grant in the following cycle (IDLE).
REQ-021 Grant SHALL remain asserted continuously from GRANT through RELEASE inclusive, and SHALL be zero in IDLE.
REQ-022 Address arithmetic SHALL wrap modulo 512; tail < head is a legal wrapped frame.
REQ-023 A request deasserting mid-frame SHALL be ignored; the frame completes and releases normally.
REQ-024 On an overflow discard, drop_count SHALL increment, saturating at 255.
REQ-025 tx_valid SHALL be low outside SEND; there SHALL be no combinational path from tx_ready to tx_valid.

Reset
REQ-026 When rst is high, state SHALL go to IDLE, grant 0, sl_latch_tail 0, tx_valid 0, tx_last 0, tx_data 0, sl_addr 0, all head pointers 0, rr_ptr 0, drop_count 0.
REQ-027 Reset mid-frame SHALL abandon the frame without pulsing sl_latch_tail.

Structure
REQ-028 State encodings and the 9-bit slave-bus address width SHALL live in the shared bus package.
REQ-029 The round-robin picker SHALL be a sub-module rr_priority_pick (request vector, start index -> one-hot grant, valid).

Verification
REQ-030 Port 1 requests, head=0, tail=3, data 0x41,0x42,0x143, tx_ready=1 -> tx bytes 41,42,43, tx_last on 43, one latch pulse, head[1]=3.
REQ-031 Ports 0 and 2 request simultaneously, rr_ptr=0 -> port 0 served first, then port 2; no overlapping grants.
REQ-032 tx_ready held low 10 cycles during SEND -> tx_data/tx_valid stable throughout, no byte lost or duplicated.
REQ-033 Port 3 with head=510, tail=2 -> addresses 510,511,0,1 read in order, head[3]=2.
REQ-034 sl_overflow=1 at GRANT -> zero tx bytes, one latch pulse, drop_count 0->1; at 255 it stays 255.
REQ-035 rst asserted in SEND -> next cycle grant=0, tx_valid=0, no latch pulse, head pointers 0.

Source files
------------

// File: rtl/sl_bus_arbiter_pkg.sv
// Shared slave-bus definitions for the frame arbiter.
// Holds the slave-bus address/data widths, their typedefs and the arbiter
// state encoding. The top, the interface and the bench all import it.
package sl_bus_arbiter_pkg;

  localparam int SL_ADDR_W = 9;
  localparam int SL_DATA_W = 9;

  typedef logic [SL_ADDR_W-1:0] sl_addr_t;
  typedef logic [SL_DATA_W-1:0] sl_data_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_READ    = 3'd2,
    ST_SEND    = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sl_bus_arbiter_if.sv
// Shared slave bus between the frame arbiter and the per-requester message
// FIFOs, plus the byte stream towards the UART transmitter.
//   sl_arb_request : per-requester "complete frame pending"
//   sl_arb_grant   : one-hot-or-zero grant
//   sl_addr        : absolute read address into the granted FIFO
//   sl_data        : read data {last marker, byte}, one cycle after sl_addr
//   sl_tail        : granted FIFO's end-of-frame address
//   sl_latch_tail  : one-cycle frame release pulse
//   sl_overflow    : granted FIFO reports a corrupted frame
//   tx_*           : valid/ready byte stream with end-of-frame flag
// Modports: master = arbiter side, slave = FIFO/transmitter side.
interface sl_bus_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  import sl_bus_arbiter_pkg::*;

  logic [NUM_PORTS-1:0] sl_arb_request;
  logic [NUM_PORTS-1:0] sl_arb_grant;
  sl_addr_t             sl_addr;
  sl_data_t             sl_data;
  sl_addr_t             sl_tail;
  logic                 sl_latch_tail;
  logic                 sl_overflow;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_last;

  modport master (
    input  sl_arb_request, sl_data, sl_tail, sl_overflow, tx_ready,
    output sl_arb_grant, sl_addr, sl_latch_tail, tx_data, tx_valid, tx_last
  );

  modport slave (
    output sl_arb_request, sl_data, sl_tail, sl_overflow, tx_ready,
    input  sl_arb_grant, sl_addr, sl_latch_tail, tx_data, tx_valid, tx_last
  );

endinterface

// File: rtl/sl_bus_arbiter_rr_priority_pick.sv
// Round-robin priority picker: returns a one-hot vector selecting the first
// set request at or after index 'start', wrapping at NUM_PORTS.
//   req      : request vector
//   start    : highest-priority index this round
//   grant_oh : one-hot pick (all zero when nothing requests)
//   valid    : at least one request is set
module rr_priority_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [NUM_PORTS-1:0] grant_oh,
  output logic                 valid
);

  function automatic logic [IDX_W-1:0] port_at(input logic [IDX_W-1:0] s, input int off);
    int sum;
    sum = (int'(s) + off) % NUM_PORTS;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_oh == '0 && req[port_at(start, i)]) grant_oh[port_at(start, i)] = 1'b1;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/sl_bus_arbiter.sv
// Frame arbiter for the shared slave bus. Picks one requester round-robin,
// streams its pending frame byte by byte to the UART transmitter and then
// releases the frame in that requester's FIFO.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : slave bus + tx stream (master modport)
//   drop_count : frames discarded because of sl_overflow, saturating at 255
module sl_bus_arbiter
  import sl_bus_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  sl_bus_arbiter_if.master bus,
  output logic [7:0]       drop_count
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e           state;
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] pick_oh;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     g_idx;
  logic [IDX_W-1:0]     rr_ptr;
  sl_addr_t             sl_addr_q;
  sl_addr_t             tail_q;
  sl_addr_t             addr_inc;
  sl_addr_t             head [NUM_PORTS];
  logic                 latch_q;
  logic                 tx_valid_q;
  logic                 last_byte;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_PORTS - 1) ? '0 : i + IDX_W'(1);
  endfunction

  rr_priority_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req      (bus.sl_arb_request),
    .start    (rr_ptr),
    .grant_oh (pick_oh),
    .valid    (pick_vld)
  );

  assign pick_idx  = oh_to_idx(pick_oh);
  assign addr_inc  = sl_addr_q + sl_addr_t'(1);
  // The marker normally ends the frame; the tail compare catches a frame
  // whose last byte was written without it.
  assign last_byte = bus.sl_data[8] | (addr_inc == tail_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      g_idx      <= '0;
      rr_ptr     <= '0;
      sl_addr_q  <= '0;
      tail_q     <= '0;
      latch_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      drop_count <= 8'd0;
      for (int i = 0; i < NUM_PORTS; i++) head[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q   <= pick_oh;
            g_idx     <= pick_idx;
            sl_addr_q <= head[pick_idx];
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          tail_q <= bus.sl_tail;
          if (bus.sl_overflow) drop_count <= sat_inc8(drop_count);
          if (bus.sl_overflow || bus.sl_tail == head[g_idx]) begin
            latch_q <= 1'b1;
            state   <= ST_RELEASE;
          end else begin
            state <= ST_READ;
          end
        end
        // sl_addr has been on the bus for one cycle when READ ends, so the
        // FIFO's registered read data is valid for the whole of SEND.
        ST_READ: begin
          tx_valid_q <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            if (last_byte) begin
              latch_q <= 1'b1;
              state   <= ST_RELEASE;
            end else begin
              sl_addr_q <= addr_inc;
              state     <= ST_READ;
            end
          end
        end
        ST_RELEASE: begin
          latch_q       <= 1'b0;
          head[g_idx]   <= tail_q;
          rr_ptr        <= wrap_inc(g_idx);
          grant_q       <= '0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sl_arb_grant  = grant_q;
  assign bus.sl_addr       = sl_addr_q;
  assign bus.sl_latch_tail = latch_q;
  assign bus.tx_valid      = tx_valid_q;
  // tx_valid_q is high exactly in SEND, where sl_addr and therefore sl_data
  // are held, so the byte is stable until the handshake.
  assign bus.tx_data       = tx_valid_q ? bus.sl_data[7:0] : 8'd0;
  assign bus.tx_last       = tx_valid_q & last_byte;

endmodule

// File: tb/tb_sl_bus_arbiter.sv
module tb_sl_bus_arbiter;
  import sl_bus_arbiter_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] drop_count;

  sl_bus_arbiter_if #(.NUM_PORTS(N)) bus ();

  sl_bus_arbiter #(.NUM_PORTS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    sl_addr_t start;
    sl_addr_t tail;
    logic     ovf;
  } frame_t;

  typedef struct packed {
    logic [3:0] port;
    sl_addr_t   addr;
    logic [7:0] data;
    logic       last;
  } beat_t;

  frame_t   env_q [N][$];
  frame_t   mdl_q [N][$];
  sl_data_t mem   [N][512];
  sl_addr_t wr    [N];
  beat_t    exp_beats[$];
  int       exp_latch[$];
  int       mdl_rr, mdl_drops;
  int       checks, errors;
  int       ready_mode;
  int       tx_count, latch_count;

  logic [N-1:0] prev_grant;
  logic         prev_latch, prev_valid, prev_ready, prev_last;
  logic [7:0]   prev_data;

  function automatic int gidx(input logic [N-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // FIFO model: registered read of the granted requester's memory
  always @(posedge clk) bus.sl_data <= mem[gidx(bus.sl_arb_grant)][bus.sl_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_list(input int p, input sl_data_t vals[$], input bit ovf);
    frame_t f;
    f.start = wr[p];
    foreach (vals[i]) begin
      mem[p][wr[p]] = vals[i];
      wr[p] = wr[p] + sl_addr_t'(1);
    end
    f.tail = wr[p];
    f.ovf  = ovf;
    env_q[p].push_back(f);
    mdl_q[p].push_back(f);
  endtask

  task automatic push_frame(input int p, input int len, input bit ovf, input bit mark);
    sl_data_t vals[$];
    for (int i = 0; i < len; i++) vals.push_back({mark && (i == len - 1), 8'($urandom)});
    push_list(p, vals, ovf);
  endtask

  // Reference: serve pending frames round-robin, one whole frame at a time.
  task automatic model_round();
    while (1) begin
      int p;
      frame_t f;
      p = -1;
      for (int k = 0; k < N; k++) begin
        int q;
        q = (mdl_rr + k) % N;
        if (p < 0 && mdl_q[q].size() != 0) p = q;
      end
      if (p < 0) break;
      f = mdl_q[p].pop_front();
      if (f.ovf) begin
        if (mdl_drops < 255) mdl_drops++;
      end else if (f.tail != f.start) begin
        sl_addr_t a;
        a = f.start;
        while (1) begin
          beat_t b;
          b.port = 4'(p);
          b.addr = a;
          b.data = mem[p][a][7:0];
          b.last = mem[p][a][8] || (a + sl_addr_t'(1) == f.tail);
          exp_beats.push_back(b);
          if (b.last) break;
          a = a + sl_addr_t'(1);
        end
      end
      exp_latch.push_back(p);
      mdl_rr = (p + 1) % N;
    end
  endtask

  task automatic monitor(input bit nready);
    int          g;
    beat_t       obs;
    logic [31:0] want;
    g = gidx(bus.sl_arb_grant);
    chk("grant_onehot0", 32'($onehot0(bus.sl_arb_grant)), 1);
    if (bus.sl_arb_grant != 0 && prev_grant == 0) begin
      want = (exp_latch.size() != 0) ? 32'(exp_latch[0]) : 32'hFFFF_FFFF;
      chk("grant_port", g, want);
      want = (env_q[g].size() != 0) ? 32'(env_q[g][0].start) : 32'hFFFF_FFFF;
      chk("head_addr", 32'(bus.sl_addr), want);
    end
    if (prev_grant != 0 && !prev_latch) chk("grant_hold", 32'(bus.sl_arb_grant), 32'(prev_grant));
    if (prev_latch) begin
      chk("grant_drop", 32'(bus.sl_arb_grant), 0);
      chk("latch_one_cycle", 32'(bus.sl_latch_tail), 0);
    end
    if (prev_valid && !prev_ready)
      chk("tx_stable", 32'({bus.tx_valid, bus.tx_last, bus.tx_data}), 32'({1'b1, prev_last, prev_data}));
    if (bus.tx_valid) chk("valid_needs_grant", 32'(bus.sl_arb_grant != 0), 1);
    if (bus.tx_valid && nready) begin
      tx_count++;
      obs.port = 4'(g);
      obs.addr = bus.sl_addr;
      obs.data = bus.tx_data;
      obs.last = bus.tx_last;
      if (exp_beats.size() != 0) chk("tx_beat", 32'(obs), 32'(exp_beats.pop_front()));
      else chk("tx_beat_extra", exp_beats.size(), 1);
    end
    if (bus.sl_latch_tail) begin
      latch_count++;
      if (exp_latch.size() != 0) want = 32'(exp_latch.pop_front());
      else want = 32'hFFFF_FFFF;
      chk("latch_port", g, want);
      chk("latch_no_tx", 32'(bus.tx_valid), 0);
      if (env_q[g].size() != 0) void'(env_q[g].pop_front());
    end
    prev_grant = bus.sl_arb_grant;
    prev_latch = bus.sl_latch_tail;
    prev_valid = bus.tx_valid;
    prev_ready = nready;
    prev_last  = bus.tx_last;
    prev_data  = bus.tx_data;
  endtask

  task automatic drive_env(input bit nready);
    int g;
    g = gidx(bus.sl_arb_grant);
    bus.tx_ready = nready;
    // While a frame is in flight the request lines are noise the DUT must ignore.
    if (bus.sl_arb_grant != 0) bus.sl_arb_request = N'($urandom);
    else for (int p = 0; p < N; p++) bus.sl_arb_request[p] = (env_q[p].size() != 0);
    if (env_q[g].size() != 0) begin
      bus.sl_tail     = env_q[g][0].tail;
      bus.sl_overflow = env_q[g][0].ovf;
    end else begin
      bus.sl_tail     = sl_addr_t'($urandom);
      bus.sl_overflow = 1'b0;
    end
  endtask

  task automatic cycle();
    bit nready;
    @(negedge clk);
    if (ready_mode == 0) nready = 1'b0;
    else if (ready_mode == 1) nready = 1'b1;
    else nready = ($urandom_range(0, 3) != 0);
    if (!rst) monitor(nready);
    else begin
      prev_grant = '0; prev_latch = 0; prev_valid = 0; prev_ready = 0;
    end
    drive_env(nready);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_latch.size() != 0 || bus.sl_arb_grant != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_done"}, 32'(n < budget), 1);
    cycle();
    chk({tag, "_drops"}, 32'(drop_count), 32'(mdl_drops));
  endtask

  task automatic wait_send(input string tag);
    int n;
    n = 0;
    while (!bus.tx_valid && n < 50) begin
      cycle();
      n++;
    end
    chk(tag, 32'(bus.tx_valid), 1);
  endtask

  task automatic clear_env();
    for (int p = 0; p < N; p++) begin
      env_q[p].delete();
      mdl_q[p].delete();
      wr[p] = '0;
    end
    exp_beats.delete();
    exp_latch.delete();
    mdl_rr = 0;
    mdl_drops = 0;
  endtask

  initial begin
    int t0, l0;
    sl_data_t v[$];
    checks = 0; errors = 0; tx_count = 0; latch_count = 0;
    for (int p = 0; p < N; p++) for (int a = 0; a < 512; a++) mem[p][a] = '0;
    clear_env();
    ready_mode = 1;
    rst = 1'b1;
    bus.sl_data = '0;
    drive_env(1'b1);
    repeat (3) cycle();
    chk("rst_grant", 32'(bus.sl_arb_grant), 0);
    chk("rst_latch", 32'(bus.sl_latch_tail), 0);
    chk("rst_valid", 32'(bus.tx_valid), 0);
    chk("rst_last", 32'(bus.tx_last), 0);
    chk("rst_data", 32'(bus.tx_data), 0);
    chk("rst_addr", 32'(bus.sl_addr), 0);
    chk("rst_drops", 32'(drop_count), 0);
    rst = 1'b0;
    cycle();

    // ports 0 and 2 together from rr_ptr 0
    push_frame(0, 3, 0, 1);
    push_frame(2, 2, 0, 1);
    model_round();
    l0 = latch_count;
    drain("rr02", 200);
    chk("rr02_latches", latch_count - l0, 2);

    // fixed three-byte frame on port 1
    v = '{9'h041, 9'h042, 9'h143};
    push_list(1, v, 0);
    model_round();
    t0 = tx_count; l0 = latch_count;
    drain("p1_fixed", 200);
    chk("p1_fixed_bytes", tx_count - t0, 3);
    chk("p1_fixed_latches", latch_count - l0, 1);

    // back-pressure for 10 cycles in SEND
    push_frame(0, 3, 0, 0);
    model_round();
    ready_mode = 0;
    t0 = tx_count;
    wait_send("stall_send");
    repeat (10) cycle();
    chk("stall_no_bytes", tx_count - t0, 0);
    ready_mode = 1;
    drain("stall", 200);
    chk("stall_bytes", tx_count - t0, 3);

    // port 3: discard up to 510, then a frame wrapping 510..1
    push_frame(3, 510, 1, 0);
    push_frame(3, 4, 0, 0);
    model_round();
    drain("wrap", 200);

    // randomized rounds
    ready_mode = 2;
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < N; p++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int k = 0; k < nf; k++)
          push_frame(p, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8),
                     ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
      end
      model_round();
      drain("rand", 3000);
    end

    // drop_count saturation
    ready_mode = 1;
    for (int r = 0; r < 66; r++) begin
      for (int p = 0; p < N; p++) push_frame(p, 0, 1, 0);
      model_round();
      drain("sat", 200);
    end
    chk("drop_sat", 32'(drop_count), 255);

    // reset while a byte is waiting in SEND
    push_frame(2, 4, 0, 1);
    model_round();
    ready_mode = 0;
    wait_send("rst_send");
    rst = 1'b1;
    clear_env();
    cycle();
    chk("mid_rst_grant", 32'(bus.sl_arb_grant), 0);
    chk("mid_rst_valid", 32'(bus.tx_valid), 0);
    chk("mid_rst_latch", 32'(bus.sl_latch_tail), 0);
    chk("mid_rst_drops", 32'(drop_count), 0);
    rst = 1'b0;
    ready_mode = 1;
    l0 = latch_count;
    repeat (5) cycle();
    chk("mid_rst_no_latch", latch_count - l0, 0);
    push_frame(3, 2, 0, 1);
    push_frame(2, 3, 0, 1);
    model_round();
    drain("post_rst", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
